// File: rtl/scanchain_reader.sv
// Deserializes scan frames (scan_clk/scan_en/scan_in/scan_reset) into address/payload pairs.
// Latency: read_valid rises 3 clk edges after the first edge that samples scan_en low at the pin.
// Backpressure: one frame is held until read_ready; a good frame closing while it is held is dropped and flagged.
module scanchain_reader #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 169,
  localparam int FRAME_BITS  = ADDR_BITS + PAYLOAD_BITS,
  localparam int CNT_BITS    = $clog2(FRAME_BITS + 2)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    scan_reset,
  output logic                    read_valid,
  input  logic                    read_ready,
  output logic [ADDR_BITS-1:0]    read_addr,
  output logic [PAYLOAD_BITS-1:0] read_payload,
  output logic                    frame_error,
  output logic                    overflow,
  output logic                    scan_reset_seen,
  output logic                    busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  localparam logic [CNT_BITS-1:0] FRAME_CNT = CNT_BITS'(FRAME_BITS);
  localparam logic [CNT_BITS-1:0] CNT_ONE   = CNT_BITS'(1);

  // [0],[1] form the synchronizer, [2] is the previous synchronized value
  logic [2:0] clk_sync;
  logic [2:0] en_sync;
  logic [2:0] rst_sync;
  logic [1:0] in_sync;

  // warm[1] marks that the synchronized samples now reflect the pins rather than reset values
  logic [1:0] warm;
  logic       en_armed;

  logic clk_rise, en_rise, en_fall, rst_rise;

  // Registered event stage keeping data, clock and enable aligned
  logic ev_clk_rise, ev_en_rise, ev_en_fall, ev_bit, ev_scan_rst;

  logic [0:0]            state;
  logic [CNT_BITS-1:0]   cnt;
  logic [FRAME_BITS-1:0] sh;

  logic [CNT_BITS-1:0]   cap_cnt;
  logic [FRAME_BITS-1:0] cap_sh;
  logic                  close_frame, close_good, close_bad, load_frame, drop_frame;

  // Two-flop synchronizers plus history register for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      en_sync  <= '0;
      rst_sync <= '0;
      in_sync  <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], scan_clk};
      en_sync  <= {en_sync[1:0], scan_en};
      rst_sync <= {rst_sync[1:0], scan_reset};
      in_sync  <= {in_sync[0], scan_in};
    end
  end

  // Frame start is armed only after scan_en has genuinely been seen low since reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      warm     <= '0;
      en_armed <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      if (warm[1] && !en_sync[1]) begin
        en_armed <= 1'b1;
      end
    end
  end

  assign clk_rise = clk_sync[1] & ~clk_sync[2];
  assign en_rise  = en_sync[1] & ~en_sync[2] & en_armed;
  assign en_fall  = ~en_sync[1] & en_sync[2];
  assign rst_rise = rst_sync[1] & ~rst_sync[2];

  // Register detected events so every decode decision sees one coherent snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ev_clk_rise     <= 1'b0;
      ev_en_rise      <= 1'b0;
      ev_en_fall      <= 1'b0;
      ev_bit          <= 1'b0;
      ev_scan_rst     <= 1'b0;
      scan_reset_seen <= 1'b0;
    end else begin
      ev_clk_rise     <= clk_rise;
      ev_en_rise      <= en_rise;
      ev_en_fall      <= en_fall;
      ev_bit          <= in_sync[1];
      ev_scan_rst     <= rst_sync[1];
      scan_reset_seen <= rst_rise;
    end
  end

  // Capture of the current bit, applied before any frame close in the same cycle
  always_comb begin
    cap_cnt = cnt;
    cap_sh  = sh;
    if (state == ST_SHIFT && ev_clk_rise) begin
      if (cnt < FRAME_CNT) begin
        cap_sh  = {sh[FRAME_BITS-2:0], ev_bit};
        cap_cnt = cnt + CNT_ONE;
      end else if (cnt == FRAME_CNT) begin
        cap_cnt = cnt + CNT_ONE;
      end
    end
  end

  assign close_frame = (state == ST_SHIFT) && ev_en_fall && !ev_scan_rst;
  assign close_good  = close_frame && (cap_cnt == FRAME_CNT);
  assign close_bad   = close_frame && (cap_cnt != FRAME_CNT);
  assign load_frame  = close_good && (!read_valid || read_ready);
  assign drop_frame  = close_good && read_valid && !read_ready;
  assign busy        = (state == ST_SHIFT);

  // Frame state machine; scan_reset aborts silently and blocks enable edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else if (ev_scan_rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_en_rise) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          cnt <= cap_cnt;
          sh  <= cap_sh;
          if (ev_en_fall) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_valid   <= 1'b0;
      read_addr    <= '0;
      read_payload <= '0;
      frame_error  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      frame_error <= close_bad;
      overflow    <= drop_frame;
      if (load_frame) begin
        read_valid   <= 1'b1;
        read_addr    <= cap_sh[FRAME_BITS-1 -: ADDR_BITS];
        read_payload <= cap_sh[PAYLOAD_BITS-1:0];
      end else if (read_valid && read_ready) begin
        read_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scanchain_reader.sv
// Self-checking bench for scanchain_reader with a 4-bit address and 8-bit payload.
// Frames are driven on the scan pins with a 20-cycle scan_clk period.
// A scoreboard queue holds frames expected to be accepted on read_valid/read_ready.
module tb_scanchain_reader;

  localparam int AB = 4;
  localparam int PB = 8;

  logic          clk;
  logic          reset;
  logic          scan_clk;
  logic          scan_en;
  logic          scan_in;
  logic          scan_reset;
  logic          read_valid;
  logic          read_ready;
  logic [AB-1:0] read_addr;
  logic [PB-1:0] read_payload;
  logic          frame_error;
  logic          overflow;
  logic          scan_reset_seen;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int n_deliv = 0;
  int n_ferr = 0;
  int n_ovf = 0;
  int n_rs = 0;
  logic [AB+PB-1:0] exp_q[$];

  scanchain_reader #(.ADDR_BITS(AB), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .reset(reset),
    .scan_clk(scan_clk), .scan_en(scan_en), .scan_in(scan_in), .scan_reset(scan_reset),
    .read_valid(read_valid), .read_ready(read_ready),
    .read_addr(read_addr), .read_payload(read_payload),
    .frame_error(frame_error), .overflow(overflow),
    .scan_reset_seen(scan_reset_seen), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: counts pulses and checks every accepted frame against the scoreboard
  initial begin
    logic [AB+PB-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (frame_error === 1'b1) n_ferr++;
      if (overflow === 1'b1) n_ovf++;
      if (scan_reset_seen === 1'b1) n_rs++;
      if (read_valid === 1'b1 && read_ready === 1'b1) begin
        n_deliv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL deliver: unexpected frame addr=%h payload=%h, none expected", read_addr, read_payload);
        end else begin
          exp = exp_q.pop_front();
          if ({read_addr, read_payload} !== exp) begin
            errors++;
            $display("FAIL deliver: got addr=%h payload=%h, expected addr=%h payload=%h",
                     read_addr, read_payload, exp[AB+PB-1 -: AB], exp[PB-1:0]);
          end
        end
      end
    end
  end

  task automatic clock_bit(input logic b, input bit drop_en);
    scan_in = b;
    repeat (10) @(negedge clk);
    scan_clk = 1'b1;
    if (drop_en) scan_en = 1'b0;
    repeat (10) @(negedge clk);
    scan_clk = 1'b0;
  endtask

  // Sends the low n bits MSB first; ends on the negedge where scan_en was dropped unless coincident
  task automatic send_frame(input logic [31:0] bits, input int n, input bit coincide);
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      clock_bit(bits[n-1-i], coincide && (i == n - 1));
    end
    if (!coincide) begin
      repeat (5) @(negedge clk);
      scan_en = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({read_valid, read_addr, read_payload, frame_error, overflow, scan_reset_seen, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b addr=%h payload=%h ferr=%b ovf=%b rs=%b busy=%b, required all 0",
               read_valid, read_addr, read_payload, frame_error, overflow, scan_reset_seen, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_good_frame();
    int d0;
    d0 = n_deliv;
    read_ready = 1'b1;
    exp_q.push_back({4'hA, 8'h5C});
    send_frame(32'hA5C, 12, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (read_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: read_valid=%b after edge k+2, required 0", read_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (read_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency_k3: read_valid=%b after edge k+3, required 1", read_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (read_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_one_cycle: read_valid=%b after acceptance, required 0", read_valid);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1) begin
      errors++;
      $display("FAIL good_count: delivered %0d frames, required 1", n_deliv - d0);
    end
  endtask

  task automatic test_backpressure();
    int o0, d0;
    o0 = n_ovf;
    d0 = n_deliv;
    read_ready = 1'b0;
    exp_q.push_back({4'h3, 8'h11});
    send_frame(32'h311, 12, 1'b0);
    repeat (10) @(negedge clk);
    send_frame(32'h722, 12, 1'b0);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (n_ovf - o0 !== 1) begin
      errors++;
      $display("FAIL overflow_count: %0d pulses, required 1", n_ovf - o0);
    end
    checks++;
    if ({read_valid, read_addr, read_payload} !== {1'b1, 4'h3, 8'h11}) begin
      errors++;
      $display("FAIL held_frame: valid=%b addr=%h payload=%h, required 1/3/11", read_valid, read_addr, read_payload);
    end
    @(negedge clk);
    read_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1 || read_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_drain: delivered %0d valid=%b, required 1 and 0", n_deliv - d0, read_valid);
    end
  endtask

  task automatic test_length_errors();
    int f0, d0;
    f0 = n_ferr;
    d0 = n_deliv;
    read_ready = 1'b1;
    send_frame(32'h5A5, 11, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (n_ferr - f0 !== 1) begin
      errors++;
      $display("FAIL short_frame_error: %0d pulses, required 1", n_ferr - f0);
    end
    send_frame(32'h1ABC, 13, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (n_ferr - f0 !== 2 || n_deliv != d0) begin
      errors++;
      $display("FAIL long_frame_error: %0d pulses %0d delivered, required 2 and 0", n_ferr - f0, n_deliv - d0);
    end
    exp_q.push_back({4'hF, 8'hFF});
    send_frame(32'hFFF, 12, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1 || n_ferr - f0 !== 2) begin
      errors++;
      $display("FAIL recover_after_error: delivered %0d errors %0d, required 1 and 2", n_deliv - d0, n_ferr - f0);
    end
  endtask

  task automatic test_scan_reset();
    int r0, f0, d0;
    r0 = n_rs;
    f0 = n_ferr;
    d0 = n_deliv;
    read_ready = 1'b1;
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 6; i++) clock_bit(i[0], 1'b0);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_mid_frame: busy=%b, required 1", busy);
    end
    @(negedge clk);
    scan_reset = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_scan_reset: busy=%b, required 0", busy);
    end
    @(negedge clk);
    scan_en = 1'b0;
    repeat (8) @(negedge clk);
    scan_reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (n_rs - r0 !== 1 || n_ferr != f0 || n_deliv != d0) begin
      errors++;
      $display("FAIL scan_reset_abort: seen %0d ferr %0d deliv %0d, required 1/0/0", n_rs - r0, n_ferr - f0, n_deliv - d0);
    end
    exp_q.push_back({4'h1, 8'h80});
    send_frame(32'h180, 12, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1) begin
      errors++;
      $display("FAIL frame_after_scan_reset: delivered %0d, required 1", n_deliv - d0);
    end
  endtask

  task automatic test_edge_coincidence();
    int d0, f0;
    d0 = n_deliv;
    f0 = n_ferr;
    read_ready = 1'b1;
    exp_q.push_back({4'h9, 8'h3C});
    send_frame(32'h93C, 12, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1 || n_ferr != f0) begin
      errors++;
      $display("FAIL coincident_close: delivered %0d ferr %0d, required 1 and 0", n_deliv - d0, n_ferr - f0);
    end
  endtask

  task automatic test_async_reset();
    int d0;
    read_ready = 1'b0;
    send_frame(32'h6AB, 12, 1'b0);
    repeat (10) @(negedge clk);
    scan_en = 1'b1;
    repeat (10) @(negedge clk);
    clock_bit(1'b1, 1'b0);
    clock_bit(1'b0, 1'b0);
    #1;
    checks++;
    if (read_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: valid=%b busy=%b, required 1 and 1", read_valid, busy);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({read_valid, read_addr, read_payload, frame_error, overflow, scan_reset_seen, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b addr=%h payload=%h ferr=%b ovf=%b rs=%b busy=%b, required all 0",
               read_valid, read_addr, read_payload, frame_error, overflow, scan_reset_seen, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    read_ready = 1'b1;
    d0 = n_deliv;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, 1'b0);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stuck_high_en: busy=%b with scan_en held high from reset, required 0", busy);
    end
    @(negedge clk);
    scan_en = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back({4'h2, 8'h4D});
    send_frame(32'h24D, 12, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (n_deliv - d0 !== 1) begin
      errors++;
      $display("FAIL frame_after_async_reset: delivered %0d, required 1", n_deliv - d0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    scan_clk   = 1'b0;
    scan_en    = 1'b0;
    scan_in    = 1'b0;
    scan_reset = 1'b0;
    read_ready = 1'b0;
    test_reset();
    test_good_frame();
    test_backpressure();
    test_length_errors();
    test_scan_reset();
    test_edge_coincidence();
    test_async_reset();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected frames never delivered, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanchain_reader.md
Name: scanchain_reader

Overview:
- Receive-side counterpart of scanchain_writer: monitors the four-wire scan interface (scan_clk, scan_en, scan_in, scan_reset) in the FPGA clock domain and deserializes each frame back into an address/payload pair.
- Used as a loopback checker on the A7 and as a chip-side scan-chain model in bench and hardware bring-up.
- Delivers decoded frames on a valid/ready interface.
- Flags length errors, overflow and scan resets.

Parameters:
- ADDR_BITS, 12, address field width.
- PAYLOAD_BITS, 169, payload field width.
- FRAME_BITS, ADDR_BITS+PAYLOAD_BITS, expected bits per frame; derived, do not override.
- CNT_BITS, $clog2(FRAME_BITS+2), bit counter width; derived.

Ports:
- clk  in  1  FPGA clock (100 MHz).
- reset  in  1  asynchronous, active-high reset.
- scan_clk  in  1  scan clock from the writer or chip; asynchronous to clk.
- scan_en  in  1  frame enable; high while shifting; asynchronous.
- scan_in  in  1  serial data; asynchronous.
- scan_reset  in  1  scan chain reset; asynchronous.
- read_valid  out  1  decoded frame available.
- read_ready  in  1  consumer accepts the frame.
- read_addr  out  ADDR_BITS  decoded address.
- read_payload  out  PAYLOAD_BITS  decoded payload.
- frame_error  out  1  1-cycle pulse: a frame closed with bit count != FRAME_BITS.
- overflow  out  1  1-cycle pulse: a good frame was dropped because read_valid was still high.
- scan_reset_seen  out  1  1-cycle pulse on the synchronized scan_reset rising edge.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset values: read_valid=0, read_addr=0, read_payload=0, frame_error=0, overflow=0, scan_reset_seen=0, busy=0. The state machine enters IDLE. The bit counter and shift register are cleared.
- Synchronization:
  - Each scan_* input passes through a 2-flop synchronizer (reset to 0).
  - A third register holds the previous synchronized value for edge detection.
  - All decoding uses synchronized values only.
  - scan_in uses the same pipeline depth as scan_clk, so data and clock stay aligned.
- Input rate requirement: each scan_clk high and low phase must be at least 3 clk cycles. Faster scan clocks are unsupported.
- Wire format: address first, then payload, each MSB first. A bit is captured on each synchronized scan_clk rising edge while synchronized scan_en=1.
- Shift register: FRAME_BITS wide, shifts left with the new bit entering the LSB. After FRAME_BITS bits, read_addr takes the top ADDR_BITS and read_payload takes the low PAYLOAD_BITS.
- State IDLE:
  - On synchronized scan_en rising edge, go to SHIFT and clear the bit counter.
  - scan_clk edges are ignored in IDLE.
- State SHIFT (busy=1):
  - Each capture shifts the register and increments the counter.
  - The counter saturates at FRAME_BITS+1.
  - Once the counter reaches FRAME_BITS, further bits do not shift the register; they only push the counter to saturation.
- Frame close, on synchronized scan_en falling edge in SHIFT:
  - If a scan_clk rising edge falls in the same clk cycle, that bit is captured first and counted.
  - Count == FRAME_BITS and read_valid=0: load read_addr/read_payload and set read_valid on the next clk edge.
  - Count == FRAME_BITS and read_valid=1: pulse overflow. The held frame is unchanged.
  - Count != FRAME_BITS, including 0: pulse frame_error and discard the frame.
  - In all three cases, return to IDLE.
- Latency: if clk edge k is the first to sample scan_en low at the pin, read_valid is high after edge k+3.
- Output handshake:
  - read_valid stays high, with read_addr/read_payload stable, until a cycle with read_valid && read_ready. It deasserts on the following edge.
  - read_addr/read_payload hold their last value after acceptance.
  - If acceptance and a new good frame close occur in the same cycle, the new frame loads and read_valid stays high. This is not an overflow.
- scan_reset:
  - Synchronized scan_reset=1 forces IDLE and clears the counter and shift register.
  - While scan_reset is high, scan_en edges are ignored.
  - A frame in progress is aborted without frame_error.
  - Any pending read_valid frame is preserved.
  - scan_reset_seen pulses once per rising edge.
- Asynchronous reset asserted mid-frame returns everything to the reset values immediately.
- After reset deasserts, scan_en must be seen low before a new frame can start. A stuck-high scan_en never starts a frame.

Test Plan:
Directed tests use ADDR_BITS=4, PAYLOAD_BITS=8, scan_clk period of 20 clk cycles.
- Good frame: shift addr=0xA, payload=0x5C, MSB first (12 bits), read_ready=1 → read_valid for 1 cycle, read_addr=0xA, read_payload=0x5C, read_valid high 3 clk edges after pin scan_en falls.
- Backpressure: read_ready=0, send 0x3/0x11 then 0x7/0x22 → first frame held, overflow pulses once, then read_ready=1 → 0x3/0x11 delivered, 0x7/0x22 never delivered.
- Length errors: 11-bit frame, then 13-bit frame → frame_error pulses each time, read_valid stays 0; a following good 12-bit frame 0xF/0xFF decodes correctly.
- scan_reset mid-frame: raise scan_reset after 6 bits → scan_reset_seen pulses once, busy falls, no frame_error; a subsequent good frame 0x1/0x80 decodes correctly.
- Edge coincidence: last scan_clk rise and scan_en fall on the same pin cycle → 12 bits counted, frame 0x9/0x3C delivered.
- Async reset asserted while read_valid=1 and in SHIFT → all outputs 0 within the same cycle; busy=0.
